// File: rtl/coordinate_bank_dispatcher_if.sv
// Batch-in / per-bank-write-out bus of the coordinate bank dispatcher.
// The master drives products and bank readiness; the slave (dispatcher) drives writes.
interface coordinate_bank_dispatcher_if #(
  parameter int LANES   = 16,
  parameter int BANKS   = 8,
  parameter int DATA_W  = 16,
  parameter int COORD_W = 16,
  parameter int DIM_W   = 9,
  parameter int ADDR_W  = 15
) ();
  logic [DIM_W-1:0]                  out_dim;
  logic                              in_valid;
  logic                              in_ready;
  logic [LANES-1:0]                  lane_valid;
  logic [LANES-1:0][DATA_W-1:0]      lane_data;
  logic [LANES-1:0][COORD_W-1:0]     lane_row;
  logic [LANES-1:0][COORD_W-1:0]     lane_col;
  logic [BANKS-1:0]                  bank_valid;
  logic [BANKS-1:0]                  bank_ready;
  logic [BANKS-1:0][ADDR_W-1:0]      bank_addr;
  logic [BANKS-1:0][DATA_W-1:0]      bank_data;
  logic                              batch_done;
  logic [15:0]                       drop_count;

  modport master (
    output out_dim, in_valid, lane_valid, lane_data, lane_row, lane_col, bank_ready,
    input  in_ready, bank_valid, bank_addr, bank_data, batch_done, drop_count
  );

  modport slave (
    input  out_dim, in_valid, lane_valid, lane_data, lane_row, lane_col, bank_ready,
    output in_ready, bank_valid, bank_addr, bank_data, batch_done, drop_count
  );
endinterface

// File: rtl/coordinate_bank_dispatcher.sv
// Filters a batch of coordinate-tagged products to the output plane and writes
// survivors to accumulator banks, serialising bank conflicts in lane order.
module coordinate_bank_dispatcher #(
  parameter int LANES   = 16,
  parameter int BANKS   = 8,
  parameter int DATA_W  = 16,
  parameter int COORD_W = 16,
  parameter int DIM_W   = 9,
  parameter int ADDR_W  = 15
) (
  input logic                        clk,
  input logic                        reset_n,
  coordinate_bank_dispatcher_if.slave bus
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int LANE_W = $clog2(LANES);
  localparam int FLAT_W = 2 * DIM_W;

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t                       state_q, state_d;
  logic [LANES-1:0]             pending_q, pending_d;
  logic [15:0]                  drop_count_q, drop_count_d;
  logic                         batch_done_q, batch_done_d;
  logic [LANES-1:0][DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0][BANK_W-1:0] bank_q, bank_d;
  logic [LANES-1:0][ADDR_W-1:0] addr_q, addr_d;

  logic                         accept;
  logic signed [COORD_W-1:0]    dim_s;
  logic [LANES-1:0]             in_range;
  logic [LANES-1:0][FLAT_W-1:0] flat;
  logic [LANE_W:0]              drop_num;
  logic [16:0]                  drop_sum;
  logic [BANKS-1:0]             grant_any;
  logic [BANKS-1:0][LANE_W-1:0] grant_idx;
  logic [LANES-1:0]             clear_mask;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign dim_s  = signed'({{(COORD_W-DIM_W){1'b0}}, bus.out_dim});

  // Only in-range lanes use flat, so truncating row/col to DIM_W bits is exact there.
  always_comb begin
    in_range = '0;
    flat     = '0;
    for (int i = 0; i < LANES; i++) begin
      in_range[i] = !bus.lane_row[i][COORD_W-1] && ($signed(bus.lane_row[i]) < dim_s) &&
                    !bus.lane_col[i][COORD_W-1] && ($signed(bus.lane_col[i]) < dim_s);
      flat[i] = FLAT_W'(bus.lane_row[i][DIM_W-1:0]) * FLAT_W'(bus.out_dim) +
                FLAT_W'(bus.lane_col[i][DIM_W-1:0]);
    end
  end

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < LANES; i++)
      drop_num = drop_num + (LANE_W+1)'(bus.lane_valid[i] & ~in_range[i]);
    drop_sum = {1'b0, drop_count_q} + 17'(drop_num);
  end

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  // Descending scan leaves the lowest-index pending lane as each bank's grant.
  always_comb begin
    grant_any = '0;
    grant_idx = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int i = LANES - 1; i >= 0; i--) begin
        if (pending_q[i] && (bank_q[i] == BANK_W'(b))) begin
          grant_any[b] = 1'b1;
          grant_idx[b] = LANE_W'(i);
        end
      end
    end
  end

  always_comb begin
    clear_mask = '0;
    for (int b = 0; b < BANKS; b++)
      if (grant_any[b] && bus.bank_ready[b]) clear_mask[grant_idx[b]] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q & ~clear_mask;
    drop_count_d = drop_count_q;
    batch_done_d = 1'b0;
    data_d       = data_q;
    bank_d       = bank_q;
    addr_d       = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d    = bus.lane_valid & in_range;
          drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
          data_d       = bus.lane_data;
          for (int i = 0; i < LANES; i++) begin
            bank_d[i] = flat[i][BANK_W-1:0];
            addr_d[i] = ADDR_W'(flat[i] >> BANK_W);
          end
          if (pending_d != '0) state_d = DISPATCH;
        end
      end
      DISPATCH: begin
        if (pending_d == '0) begin
          state_d      = IDLE;
          batch_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      drop_count_q <= '0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      drop_count_q <= drop_count_d;
      batch_done_q <= batch_done_d;
    end
  end

  // NOTE: lane payload arrays carry no reset; pending_q gates every use, so stale contents are harmless.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    bank_q <= bank_d;
    addr_q <= addr_d;
  end

  always_comb begin
    bus.bank_addr = '0;
    bus.bank_data = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (grant_any[b]) begin
        bus.bank_addr[b] = addr_q[grant_idx[b]];
        bus.bank_data[b] = data_q[grant_idx[b]];
      end
    end
  end

  assign bus.bank_valid = grant_any;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.batch_done = batch_done_q;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_coordinate_bank_dispatcher.sv
// Scoreboard bench for coordinate_bank_dispatcher: a lane-level model queues the
// expected writes per bank; a negedge monitor pops them as writes complete.
module tb_coordinate_bank_dispatcher;
  localparam int LANES = 16, BANKS = 8, DATA_W = 16, COORD_W = 16, DIM_W = 9, ADDR_W = 15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  coordinate_bank_dispatcher_if #(.LANES(LANES), .BANKS(BANKS), .DATA_W(DATA_W),
    .COORD_W(COORD_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  coordinate_bank_dispatcher #(.LANES(LANES), .BANKS(BANKS), .DATA_W(DATA_W),
    .COORD_W(COORD_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  wr_t              exp_q[BANKS][$];
  int               n_checks = 0, n_fail = 0;
  int               exp_done = 0, done_seen = 0, exp_drop = 0;
  int               st_row[LANES], st_col[LANES], st_dim;
  logic [DATA_W-1:0] st_data[LANES];
  logic [LANES-1:0] st_valid;

  // Monitor: every completed write must match the head of that bank's queue.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int b = 0; b < BANKS; b++) begin
        if (bus.bank_valid[b] && bus.bank_ready[b]) begin
          n_checks++;
          if (exp_q[b].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write bank %0d: got addr %0d data %h, none expected",
                     b, bus.bank_addr[b], bus.bank_data[b]);
          end else begin
            wr_t e;
            e = exp_q[b].pop_front();
            if ({bus.bank_addr[b], bus.bank_data[b]} !== e) begin
              n_fail++;
              $display("FAIL bank_write bank %0d: got addr %0d data %h, want addr %0d data %h",
                       b, bus.bank_addr[b], bus.bank_data[b], e.addr, e.data);
            end
          end
        end
      end
      if (bus.batch_done) done_seen++;
    end
  end

  task automatic clear_stim();
    st_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      st_row[i]  = -1;
      st_col[i]  = -1;
      st_data[i] = DATA_W'($urandom);
    end
  endtask

  // Drives one batch (DUT must be idle), updating the model, then scrambles the inputs.
  task automatic offer();
    int cnt, drops, flat;
    wr_t w;
    cnt = 0;
    drops = 0;
    for (int i = 0; i < LANES; i++) begin
      bus.lane_row[i]   = COORD_W'(st_row[i]);
      bus.lane_col[i]   = COORD_W'(st_col[i]);
      bus.lane_data[i]  = st_data[i];
      bus.lane_valid[i] = st_valid[i];
      if (st_valid[i]) begin
        if (st_row[i] >= 0 && st_row[i] < st_dim && st_col[i] >= 0 && st_col[i] < st_dim) begin
          flat   = st_row[i] * st_dim + st_col[i];
          w.addr = ADDR_W'(flat / BANKS);
          w.data = st_data[i];
          exp_q[flat % BANKS].push_back(w);
          cnt++;
        end else drops++;
      end
    end
    exp_drop += drops;
    if (exp_drop > 65535) exp_drop = 65535;
    if (cnt > 0) exp_done++;
    bus.out_dim  = DIM_W'(st_dim);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.out_dim    = DIM_W'(3);
    bus.lane_valid = LANES'($urandom);
    for (int i = 0; i < LANES; i++) bus.lane_data[i] = DATA_W'($urandom);
  endtask

  task automatic wait_idle(input int bound, input bit rnd);
    int k;
    k = 0;
    forever begin
      if (rnd) begin
        @(posedge clk);
        #1;
        bus.bank_ready = BANKS'($urandom);
      end
      @(negedge clk);
      if (bus.in_ready) break;
      k++;
      if (k >= bound) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: in_ready still %b after %0d cycles, want 1", bus.in_ready, k);
        break;
      end
    end
    if (rnd) bus.bank_ready = '1;
  endtask

  task automatic check_drop(input string tag);
    n_checks++;
    if (bus.drop_count !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL drop_count %s: got %0d, want %0d", tag, bus.drop_count, exp_drop);
    end
  endtask

  task automatic check_ctl(input string tag, input logic rdy, input logic [BANKS-1:0] bv,
                           input logic done);
    n_checks++;
    if ({bus.in_ready, bus.bank_valid, bus.batch_done} !== {rdy, bv, done}) begin
      n_fail++;
      $display("FAIL %s: got in_ready %b bank_valid %b batch_done %b, want %b %b %b",
               tag, bus.in_ready, bus.bank_valid, bus.batch_done, rdy, bv, done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_ctl(tag, 1'b1, '0, 1'b0);
    n_checks++;
    if (bus.bank_addr !== '0 || bus.bank_data !== '0 || bus.drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_bus: got addr %h data %h drop %0d, want all zero",
               tag, bus.bank_addr, bus.bank_data, bus.drop_count);
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_dim    = '0;
    bus.lane_valid = '0;
    bus.lane_data  = '0;
    bus.lane_row   = '0;
    bus.lane_col   = '0;
    bus.bank_ready = '1;
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_parallel();
    clear_stim();
    st_dim = 8;
    for (int i = 0; i < 8; i++) begin
      st_valid[i] = 1'b1;
      st_row[i] = 0;
      st_col[i] = i;
    end
    offer();
    @(negedge clk);
    check_ctl("parallel_first", 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    check_ctl("parallel_done", 1'b1, 8'h00, 1'b1);
    check_drop("parallel");
  endtask

  task automatic test_conflict();
    clear_stim();
    st_dim = 8;
    for (int i = 0; i < 4; i++) begin
      st_valid[i] = 1'b1;
      st_row[i] = i;
      st_col[i] = 0;
    end
    offer();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_ctl("conflict_busy", 1'b0, 8'h01, 1'b0);
    end
    @(negedge clk);
    check_ctl("conflict_done", 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_drop();
    clear_stim();
    st_dim = 8;
    st_valid[2:0] = 3'b111;
    st_row[0] = -1; st_col[0] = 2;
    st_row[1] = 2;  st_col[1] = 8;
    st_row[2] = 7;  st_col[2] = 7;
    offer();
    @(negedge clk);
    check_ctl("drop_write", 1'b0, 8'h80, 1'b0);
    n_checks++;
    if (bus.bank_addr[7] !== ADDR_W'(7)) begin
      n_fail++;
      $display("FAIL drop_addr: got %0d, want 7", bus.bank_addr[7]);
    end
    wait_idle(20, 1'b0);
    check_drop("drop");
  endtask

  task automatic test_all_drop();
    clear_stim();
    st_dim = 8;
    st_valid = '1;
    for (int i = 0; i < LANES; i++) begin
      st_row[i] = (i % 2 == 0) ? -5 : 0;
      st_col[i] = (i % 2 == 0) ? 1 : 20;
    end
    offer();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_ctl("all_drop_idle", 1'b1, 8'h00, 1'b0);
    end
    check_drop("all_drop");
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_data;
    clear_stim();
    st_dim = 8;
    for (int i = 0; i < 8; i++) begin
      st_valid[i] = 1'b1;
      st_row[i] = 1;
      st_col[i] = i;
    end
    bus.bank_ready = 8'hF7;
    offer();
    @(negedge clk);
    check_ctl("stall_first", 1'b0, 8'hFF, 1'b0);
    held_addr = bus.bank_addr[3];
    held_data = bus.bank_data[3];
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check_ctl("stall_hold", 1'b0, 8'h08, 1'b0);
      n_checks++;
      if (bus.bank_addr[3] !== held_addr || bus.bank_data[3] !== held_data) begin
        n_fail++;
        $display("FAIL stall_stable: got addr %0d data %h, want addr %0d data %h",
                 bus.bank_addr[3], bus.bank_data[3], held_addr, held_data);
      end
    end
    @(posedge clk);
    #1;
    bus.bank_ready = '1;
    @(negedge clk);
    check_ctl("stall_release", 1'b0, 8'h08, 1'b0);
    @(negedge clk);
    check_ctl("stall_done", 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    clear_stim();
    st_dim = 8;
    for (int i = 0; i < 4; i++) begin
      st_valid[i] = 1'b1;
      st_row[i] = i + 2;
      st_col[i] = 0;
    end
    bus.bank_ready = '0;
    offer();
    @(negedge clk);
    check_ctl("reset_mid_busy", 1'b0, 8'h01, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    for (int b = 0; b < BANKS; b++) exp_q[b].delete();
    exp_drop = 0;
    exp_done--;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.bank_ready = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_ctl("reset_mid_quiet", 1'b1, 8'h00, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int dims[3] = '{5, 8, 13};
    for (int n = 0; n < 8; n++) begin
      clear_stim();
      st_dim = dims[n % 3];
      st_valid = LANES'($urandom);
      for (int i = 0; i < LANES; i++) begin
        st_row[i] = int'($urandom_range(st_dim + 3, 0)) - 2;
        st_col[i] = int'($urandom_range(st_dim + 3, 0)) - 2;
      end
      if (n == 0) begin
        st_row[5] = 1; st_col[5] = 2;
        st_row[9] = 1; st_col[9] = 2;
        st_valid[5] = 1'b1;
        st_valid[9] = 1'b1;
      end
      offer();
      wait_idle(300, 1'b1);
      check_drop("back_to_back");
    end
  endtask

  task automatic test_saturate();
    clear_stim();
    st_dim = 8;
    st_valid = '1;
    for (int i = 0; i < LANES; i++) st_row[i] = 9;
    offer();
    for (int i = 0; i < LANES; i++) bus.lane_row[i] = COORD_W'(st_row[i]);
    bus.lane_valid = '1;
    bus.out_dim = DIM_W'(8);
    bus.in_valid = 1'b1;
    repeat (4100) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_drop += 4100 * LANES;
    if (exp_drop > 65535) exp_drop = 65535;
    @(negedge clk);
    check_drop("saturate");
    check_ctl("saturate_idle", 1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_conflict();
    test_drop();
    test_all_drop();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    repeat (3) @(negedge clk);
    for (int b = 0; b < BANKS; b++) begin
      n_checks++;
      if (exp_q[b].size() != 0) begin
        n_fail++;
        $display("FAIL missing_writes bank %0d: got %0d left over, want 0", b, exp_q[b].size());
      end
    end
    n_checks++;
    if (done_seen != exp_done) begin
      n_fail++;
      $display("FAIL batch_done_count: got %0d, want %0d", done_seen, exp_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
